// File: rtl/locked_adder_hd_meter.sv
// rtl/locked_adder_hd_meter.sv - Hamming-distance scoring of a key-locked adder over a vector window
//
// Purpose:
//   Recomputes the golden sum A+B for each vector, XORs it with the locked
//   adder's result and counts the corrupted output bits. Over a window of
//   win_len_i accepted vectors it accumulates the total distance, the number
//   of mismatching vectors and the worst single-vector distance.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      pulse in IDLE: clear accumulators, latch win_len_i, open window
//   win_len_i    vectors in the window (0 gives an empty window)
//   vld_i        add1_i/add2_i/dut_res_i triple valid this cycle
//   add1_i       operand A as applied to the locked adder
//   add2_i       operand B as applied to the locked adder
//   dut_res_i    locked adder result (WIDTH+1 bits, carry included)
//   busy_o       high in RUN and DRAIN
//   done_o       one-cycle pulse when the window results are final
//   hd_sum_o     saturating sum of per-vector distances
//   err_cnt_o    saturating count of vectors with non-zero distance
//   max_hd_o     largest per-vector distance seen in the window

module locked_adder_hd_meter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    localparam int HD_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [15:0]      win_len_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   dut_res_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] hd_sum_o,
    output logic [15:0]      err_cnt_o,
    output logic [HD_W-1:0]  max_hd_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;

    logic [15:0] len_q;
    logic [15:0] cnt_q;

    // Pipeline stage registers
    logic             s1_vld;
    logic [WIDTH:0]   s1_diff;
    logic             s2_vld;
    logic [HD_W-1:0]  s2_hd;

    logic             accept;
    logic             start_acc;
    logic [WIDTH:0]   golden;
    logic [HD_W-1:0]  popcnt;
    logic [CNT_W:0]   sum_ext;
    logic [16:0]      err_ext;

    // Vectors are taken only while the window still has room; once the last
    // one is accepted the FSM has already left RUN, so extras fall away.
    assign accept    = (state == ST_RUN) && vld_i && (cnt_q < len_q);
    assign start_acc = (state == ST_IDLE) && start_i;

    // Zero-extend before adding so the carry-out is compared too.
    assign golden = {1'b0, add1_i} + {1'b0, add2_i};

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WIDTH + 1; i++) begin
            popcnt = popcnt + HD_W'(s1_diff[i]);
        end
    end

    // One extra bit on each accumulator exposes overflow for saturation.
    assign sum_ext = {1'b0, hd_sum_o} + (CNT_W + 1)'(s2_hd);
    assign err_ext = {1'b0, err_cnt_o} + 17'(s2_hd != '0);

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        len_q  <= win_len_i;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                        state  <= (win_len_i != 16'd0) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q + 16'd1 == len_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait until the last accepted vector has reached the
                    // accumulators before declaring the results final.
                    if (!s1_vld && !s2_vld) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath pipeline: S1 diff, S2 popcount
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_diff <= '0;
            s2_vld  <= 1'b0;
            s2_hd   <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_diff <= dut_res_i ^ golden;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_hd <= popcnt;
            end
        end
    end

    // Accumulators (S3). The pipe is always empty in IDLE, so a clear on
    // start never collides with an in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_sum_o  <= '0;
            err_cnt_o <= '0;
            max_hd_o  <= '0;
        end else if (start_acc) begin
            hd_sum_o  <= '0;
            err_cnt_o <= '0;
            max_hd_o  <= '0;
        end else if (s2_vld) begin
            hd_sum_o  <= sum_ext[CNT_W] ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];
            err_cnt_o <= err_ext[16] ? 16'hFFFF : err_ext[15:0];
            if (s2_hd > max_hd_o) begin
                max_hd_o <= s2_hd;
            end
        end
    end

endmodule

// File: tb/tb_locked_adder_hd_meter.sv
// tb/tb_locked_adder_hd_meter.sv - directed self-checking bench for locked_adder_hd_meter

module tb_locked_adder_hd_meter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] win_len_i;
    logic        vld_i;
    logic [15:0] add1_i;
    logic [15:0] add2_i;
    logic [16:0] dut_res_i;

    logic        busy_o, done_o;
    logic [31:0] hd_sum_o;
    logic [15:0] err_cnt_o;
    logic [4:0]  max_hd_o;

    logic        busy8, done8;
    logic [7:0]  hd_sum8;
    logic [15:0] err_cnt8;
    logic [4:0]  max_hd8;

    int vecs = 0;
    int errs = 0;
    int first_done;
    int done_pulses;

    locked_adder_hd_meter #(.WIDTH(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .win_len_i(win_len_i),
        .vld_i(vld_i), .add1_i(add1_i), .add2_i(add2_i), .dut_res_i(dut_res_i),
        .busy_o(busy_o), .done_o(done_o), .hd_sum_o(hd_sum_o),
        .err_cnt_o(err_cnt_o), .max_hd_o(max_hd_o)
    );

    locked_adder_hd_meter #(.WIDTH(16), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start_i), .win_len_i(win_len_i),
        .vld_i(vld_i), .add1_i(add1_i), .add2_i(add2_i), .dut_res_i(dut_res_i),
        .busy_o(busy8), .done_o(done8), .hd_sum_o(hd_sum8),
        .err_cnt_o(err_cnt8), .max_hd_o(max_hd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_win(input logic [15:0] len);
        start_i   = 1'b1;
        win_len_i = len;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
        vld_i     = 1'b1;
        add1_i    = a;
        add2_i    = b;
        dut_res_i = r;
        @(negedge clk);
        vld_i     = 1'b0;
    endtask

    // Bounded watch of done_o: first cycle seen (0 = never) and pulse count.
    task automatic wait_done(input int budget);
        first_done  = 0;
        done_pulses = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done_o) begin
                done_pulses++;
                if (first_done == 0) first_done = k;
            end
        end
    endtask

    task automatic check_results(input string name, input logic [31:0] hs,
                                 input logic [15:0] ec, input logic [4:0] mx);
        vecs++;
        if (hd_sum_o !== hs) begin
            errs++;
            $display("FAIL %s hd_sum got %h want %h", name, hd_sum_o, hs);
        end
        vecs++;
        if (err_cnt_o !== ec) begin
            errs++;
            $display("FAIL %s err_cnt got %h want %h", name, err_cnt_o, ec);
        end
        vecs++;
        if (max_hd_o !== mx) begin
            errs++;
            $display("FAIL %s max_hd got %0d want %0d", name, max_hd_o, mx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; win_len_i = 0; vld_i = 0;
        add1_i = 0; add2_i = 0; dut_res_i = 0;
        repeat (2) @(negedge clk);
        check_results("reset", 32'h0, 16'h0, 5'd0);
        vecs++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errs++;
            $display("FAIL reset busy/done got %b%b want 00", busy_o, done_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct_key();
        start_win(16'd4);
        vecs++;
        if (busy_o !== 1'b1) begin
            errs++;
            $display("FAIL correct_key busy got %b want 1", busy_o);
        end
        apply(16'h1234, 16'h4321, 17'h05555);
        apply(16'h0000, 16'h0000, 17'h00000);
        apply(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        apply(16'h8000, 16'h8000, 17'h10000);
        wait_done(10);
        vecs++;
        if (first_done !== 3) begin
            errs++;
            $display("FAIL correct_key done_latency got %0d want 3", first_done);
        end
        vecs++;
        if (done_pulses !== 1) begin
            errs++;
            $display("FAIL correct_key done_pulses got %0d want 1", done_pulses);
        end
        check_results("correct_key", 32'h0, 16'h0, 5'd0);
    endtask

    task automatic test_carry_out();
        start_win(16'd1);
        apply(16'hFFFF, 16'h0001, 17'h00000);
        wait_done(10);
        vecs++;
        if (done_pulses !== 1) begin
            errs++;
            $display("FAIL carry done_pulses got %0d want 1", done_pulses);
        end
        check_results("carry", 32'h1, 16'h1, 5'd1);
    endtask

    task automatic test_full_inversion();
        start_win(16'd3);
        apply(16'h1234, 16'h4321, 17'h1AAAA);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'hFFFF, 16'h0001, 17'h0FFFF);
        wait_done(10);
        check_results("inv3", 32'h33, 16'h3, 5'd17);
        start_win(16'd4);
        apply(16'h1234, 16'h4321, 17'h1AAAA);
        apply(16'h0001, 16'h0001, 17'h00002);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'hFFFF, 16'h0001, 17'h0FFFF);
        wait_done(10);
        check_results("inv_mix", 32'h33, 16'h3, 5'd17);
    endtask

    task automatic test_extra_vld();
        start_win(16'd2);
        apply(16'h0000, 16'h0000, 17'h00007);
        apply(16'h0000, 16'h0000, 17'h00001);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        wait_done(10);
        vecs++;
        if (done_pulses !== 1) begin
            errs++;
            $display("FAIL extra_vld done_pulses got %0d want 1", done_pulses);
        end
        check_results("extra_vld", 32'h4, 16'h2, 5'd3);
    endtask

    task automatic test_zero_window();
        // Previous window's results remain visible in IDLE until next start.
        check_results("hold_idle", 32'h4, 16'h2, 5'd3);
        start_win(16'd0);
        vecs++;
        if (busy_o !== 1'b1) begin
            errs++;
            $display("FAIL zero_win busy got %b want 1", busy_o);
        end
        check_results("zero_clear", 32'h0, 16'h0, 5'd0);
        vld_i = 1'b1; add1_i = 16'h0; add2_i = 16'h0; dut_res_i = 17'h1FFFF;
        wait_done(6);
        vld_i = 1'b0;
        vecs++;
        if (first_done !== 1 || done_pulses !== 1) begin
            errs++;
            $display("FAIL zero_win done first=%0d pulses=%0d want 1/1", first_done, done_pulses);
        end
        vecs++;
        if (busy_o !== 1'b0) begin
            errs++;
            $display("FAIL zero_win busy_after got %b want 0", busy_o);
        end
        check_results("zero_win", 32'h0, 16'h0, 5'd0);
    endtask

    task automatic test_saturation();
        logic [15:0] a, b;
        start_win(16'd16);
        for (int i = 0; i < 16; i++) begin
            a = 16'(i * 37);
            b = 16'(i * 1000 + 5);
            apply(a, b, ~({1'b0, a} + {1'b0, b}));
        end
        wait_done(10);
        vecs++;
        if (hd_sum8 !== 8'hFF) begin
            errs++;
            $display("FAIL sat hd_sum8 got %h want ff", hd_sum8);
        end
        vecs++;
        if (err_cnt8 !== 16'd16 || max_hd8 !== 5'd17) begin
            errs++;
            $display("FAIL sat err8/max8 got %0d/%0d want 16/17", err_cnt8, max_hd8);
        end
        check_results("sat32", 32'd272, 16'd16, 5'd17);
    endtask

    task automatic test_reset_mid_run();
        start_win(16'd5);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'h1234, 16'h4321, 17'h1AAAA);
        rst = 1'b1;
        #1;
        check_results("rst_mid", 32'h0, 16'h0, 5'd0);
        vecs++;
        if (busy_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid busy got %b want 0", busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        wait_done(8);
        vecs++;
        if (done_pulses !== 0) begin
            errs++;
            $display("FAIL rst_mid done_pulses got %0d want 0", done_pulses);
        end
        check_results("rst_idle", 32'h0, 16'h0, 5'd0);
        start_win(16'd1);
        apply(16'hFFFF, 16'h0001, 17'h00000);
        wait_done(10);
        vecs++;
        if (done_pulses !== 1) begin
            errs++;
            $display("FAIL rst_fresh done_pulses got %0d want 1", done_pulses);
        end
        check_results("rst_fresh", 32'h1, 16'h1, 5'd1);
    endtask

    task automatic test_start_in_run();
        start_win(16'd2);
        start_i = 1'b1; win_len_i = 16'd1;
        apply(16'h0000, 16'h0000, 17'h1FFFF);
        start_i = 1'b0;
        apply(16'hFFFF, 16'h0001, 17'h00000);
        wait_done(10);
        vecs++;
        if (done_pulses !== 1) begin
            errs++;
            $display("FAIL start_in_run done_pulses got %0d want 1", done_pulses);
        end
        check_results("start_in_run", 32'd18, 16'd2, 5'd17);
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_carry_out();
        test_full_inversion();
        test_extra_vld();
        test_zero_window();
        test_saturation();
        test_reset_mid_run();
        test_start_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
